// File: rtl/rgb_pwm_driver.sv
// Three-channel 8-bit PWM LED driver; duties are latched only at period boundaries.
// Latency: outputs registered from next-state values; backpressure: none (free-running consumer).
module rgb_pwm_driver #(
   parameter int PRESCALE     = 4,
   parameter bit COMMON_ANODE = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] r_in,
   input  logic [7:0] g_in,
   input  logic [7:0] b_in,
   input  logic       enable,
   output logic       pwm_r,
   output logic       pwm_g,
   output logic       pwm_b,
   output logic       period_start,
   output logic       busy
);

   localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        r_state, w_state_nx;
   logic [PW-1:0] r_presc, w_presc_nx;
   logic [7:0]    r_phase, w_phase_nx;
   logic [7:0]    r_duty_r, r_duty_g, r_duty_b;
   logic [7:0]    w_duty_r_nx, w_duty_g_nx, w_duty_b_nx;
   logic          r_pwm_r, r_pwm_g, r_pwm_b, r_period_start, r_busy;
   logic          w_run_nx;

   always_comb begin
      w_state_nx  = r_state;
      w_presc_nx  = r_presc;
      w_phase_nx  = r_phase;
      w_duty_r_nx = r_duty_r;
      w_duty_g_nx = r_duty_g;
      w_duty_b_nx = r_duty_b;
      case (r_state)
         IDLE: begin
            w_presc_nx = '0;
            w_phase_nx = '0;
            if (enable) begin
               w_state_nx  = RUN;
               w_duty_r_nx = r_in;
               w_duty_g_nx = g_in;
               w_duty_b_nx = b_in;
            end
         end
         RUN: begin
            if (r_presc == PMAX) begin
               w_presc_nx = '0;
               w_phase_nx = r_phase + 8'd1;
               // Period end: only here does enable or the colour input matter.
               if (r_phase == 8'd255) begin
                  if (enable) begin
                     w_duty_r_nx = r_in;
                     w_duty_g_nx = g_in;
                     w_duty_b_nx = b_in;
                  end else begin
                     w_state_nx = IDLE;
                  end
               end
            end else begin
               w_presc_nx = r_presc + PW'(1);
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

   assign w_run_nx = (w_state_nx == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_presc        <= '0;
         r_phase        <= '0;
         r_duty_r       <= '0;
         r_duty_g       <= '0;
         r_duty_b       <= '0;
         r_pwm_r        <= COMMON_ANODE;
         r_pwm_g        <= COMMON_ANODE;
         r_pwm_b        <= COMMON_ANODE;
         r_period_start <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         r_state        <= w_state_nx;
         r_presc        <= w_presc_nx;
         r_phase        <= w_phase_nx;
         r_duty_r       <= w_duty_r_nx;
         r_duty_g       <= w_duty_g_nx;
         r_duty_b       <= w_duty_b_nx;
         r_pwm_r        <= (w_run_nx && (w_phase_nx < w_duty_r_nx)) ^ COMMON_ANODE;
         r_pwm_g        <= (w_run_nx && (w_phase_nx < w_duty_g_nx)) ^ COMMON_ANODE;
         r_pwm_b        <= (w_run_nx && (w_phase_nx < w_duty_b_nx)) ^ COMMON_ANODE;
         r_period_start <= w_run_nx && (w_phase_nx == 8'd0) && (w_presc_nx == '0);
         r_busy         <= w_run_nx;
      end
   end

   assign pwm_r        = r_pwm_r;
   assign pwm_g        = r_pwm_g;
   assign pwm_b        = r_pwm_b;
   assign period_start = r_period_start;
   assign busy         = r_busy;

endmodule

// File: doc/rgb_pwm_driver.md
# rgb_pwm_driver

Reads the three 8-bit colour levels held in the RGB memory unit and converts them into three pulse-width-modulated LED drive signals. It sits between the colour storage and the physical RGB LED pins, and is the consumer of the stored values. Duty values are captured only at period boundaries, so writes to the memory never produce a truncated or glitched pulse.

## Interface

Parameters:
- PRESCALE, default 4: clock cycles per PWM slot; legal range 1..65535.
- COMMON_ANODE, default 0: when 1, LED outputs are active-low (every pwm_* output is inverted).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- r_in  input  8  red level from colour memory.
- g_in  input  8  green level from colour memory.
- b_in  input  8  blue level from colour memory.
- enable  input  1  run request; sampled every clk.
- pwm_r  output  1  red LED drive, registered.
- pwm_g  output  1  green LED drive, registered.
- pwm_b  output  1  blue LED drive, registered.
- period_start  output  1  one-cycle pulse marking the first cycle of each PWM period.
- busy  output  1  high while in RUN.

## Operation

- Internal state:
  - state ∈ {IDLE, RUN}
  - presc counter, width ceil(log2(PRESCALE)), min 1
  - phase, 8-bit
  - duty_r/g/b shadow registers, 8-bit
- Reset (rst_n low, asynchronous): state=IDLE, presc=0, phase=0, shadows=0, period_start=0, busy=0, pwm_*=COMMON_ANODE.
- IDLE:
  - presc and phase held at 0; pwm_* inactive.
  - enable=1 at an edge → RUN. At the same edge: shadows ← r_in/g_in/b_in, presc ← 0, phase ← 0.
- RUN:
  - presc increments each cycle.
  - When presc==PRESCALE-1: presc ← 0, phase ← phase+1, wrapping modulo 256 (255 → 0).
- Period end (RUN, presc==PRESCALE-1 and phase==255):
  - enable=1: shadows reload from inputs; phase wraps to 0; RUN continues.
  - enable=0: → IDLE; outputs go inactive at that edge.
- enable dropping mid-period does not stop the block: the current period always completes.
- Input changes between period boundaries are ignored.
- Drive rule: in every cycle, active(pwm_x) = (state==RUN) && (phase < duty_x). The output level is active XOR COMMON_ANODE.
  - Each output register is loaded from next-state values, so the output is aligned with the phase of the same cycle.
- Duty arithmetic:
  - Unsigned 8-bit compare.
  - duty 0: never active.
  - duty 255: active 255 of 256 slots; full-on is not supported.
- period_start = 1 exactly in cycles where state==RUN, phase==0, presc==0.
- busy = (state==RUN).

## Timing

- Period length: 256 × PRESCALE cycles. Active time per period: duty × PRESCALE cycles, starting at the first cycle of the period.
- Start latency:
  - enable sampled high at edge k in IDLE.
  - At edge k: period_start=1, busy=1, pwm_x active iff duty_x > 0.
- Update latency: an input change is reflected from the first cycle of the next period; worst case 256 × PRESCALE cycles.
- Stop latency: enable low → outputs inactive at the period-end edge, at most 256 × PRESCALE cycles later.
- Back-to-back periods have no gap cycles: the cycle after phase 255's last slot is phase 0 with period_start=1.
- enable toggling within a period has no effect, except its value sampled at the period-end edge.
- Reset asserted mid-period:
  - Outputs go to reset values immediately, with no clock needed.
  - After release, the block stays in IDLE until enable is sampled high.
- PRESCALE=1: phase advances every cycle; presc is constant 0.

## Test plan

- Reset: hold rst_n=0 with enable=1 and inputs 0xFF → pwm_*=0, busy=0, period_start=0. With COMMON_ANODE=1, pwm_*=1.
- Duty sweep, PRESCALE=1: r=0, g=128, b=255, enable=1 for 3 periods → per 256-cycle period, pwm_r high 0 cycles, pwm_g 128 (cycles 0-127), pwm_b 255. period_start every 256 cycles.
- Prescale, PRESCALE=4: r=3 → pwm_r high exactly 12 cycles per 1024-cycle period. period_start spacing is 1024.
- Shadowing: r=10, then set r=200 at cycle 50 of a period → current period high 10 slots, next period high 200 slots. No intermediate pulse width.
- Stop: drop enable at phase 100 → period completes (period_start not reasserted). busy falls and outputs go inactive at the period-end edge; re-assert enable → period_start on the enabling edge.
- Async reset mid-RUN at phase 60 while pwm_g is high → outputs and busy clear without a clock edge. After release with enable=1, a fresh period starts from phase 0.
